dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Load/store sequencer between the CPU load-store stage and the word-wide synchronous data memory.
- The data memory has a 1-cycle registered read, a single write enable and no byte enables.
- Byte and halfword stores are therefore done as read-modify-write (RMW).
- Also handles load lane extraction and sign/zero extension, misalignment and illegal-size detection, and one-outstanding-request flow control.

Parameters:
- ADDR_W, 12, word-address width of the data memory. The byte address uses bits [ADDR_W+1:0].

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  CPU request present
- req_ready  output  1  controller can accept; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  loads: zero-extend when 1, sign-extend when 0
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (lane 0)
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  valid with resp_valid; misaligned, illegal size, or range fault
- mem_addr  output  ADDR_W  word address to data memory
- mem_we  output  1  data-memory write enable
- mem_din  output  32  data-memory write data
- mem_dout  input  32  data-memory read data, valid the cycle after its address was presented

Behaviour:
- Reset values: state IDLE, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_din=0. Request capture registers are cleared.
- Handshake: a request is accepted on a rising edge with req_valid && req_ready. All req_* fields are captured at that edge and are don't-care afterwards.
- Only one request is outstanding at a time. There is no response backpressure.
- mem_addr is always the captured req_addr[ADDR_W+1:2]. Upper address bits alias (but see the optional feature).
- Error check at accept:
  - size==11 is an error.
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]!=0 is misaligned.
  - Errored requests go to RESP directly, with no memory access and mem_we never asserted.
- FSM states: IDLE, READ, MERGE, WRITE, RESP.
- IDLE -> RESP on an errored request.
- IDLE -> WRITE on a word store.
- IDLE -> READ on a load or a sub-word store.
- READ (mem_we=0, address presented):
  - load: -> RESP
  - sub-word store: -> MERGE
- MERGE (mem_we=1):
  - mem_din = mem_dout with the addressed lane(s) replaced by req_wdata[7:0] or [15:0].
  - Byte lane k = addr[1:0] occupies bits [8k+7:8k]. Half uses lane addr[1]*16.
  - -> RESP.
- WRITE (mem_we=1, mem_din=req_wdata) -> RESP.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE. req_ready returns high the following cycle.
- Load data: the lane is selected from mem_dout sampled at the end of READ, then extended to 32 bits per req_unsigned. Word loads ignore req_unsigned.
- resp_rdata/resp_err are registered and hold their last value while resp_valid=0.
- Latency from accept edge to resp_valid: error 1 cycle; load 2; word store 2; sub-word store 3.
- Back-to-back throughput: the next accept is possible 1 cycle after the RESP cycle.
- mem_we is high only in MERGE or WRITE, and for exactly one cycle per store.
- Reset mid-operation: an immediate return to IDLE with all outputs at reset values.
  - If rst_n falls before the MERGE/WRITE rising edge, no write occurs.
  - The pending response is dropped.
- req_valid deasserting while not ready has no effect. Requests presented outside IDLE are ignored, not queued.

Optional Feature:
- Macro: DMEM_RANGE_CHK_EN.
- Defined: a request with any nonzero bit in req_addr[31:ADDR_W+2] is flagged as an error at accept. It takes the error path: no memory access, resp_err=1, 1-cycle latency.
- Undefined: upper address bits are ignored and the address wraps modulo 2^(ADDR_W+2) bytes.

Test Plan:
- Word store addr 0x0000_0010 data 0xDEADBEEF, then word load addr 0x10 -> mem_we pulses once with mem_addr=4; load resp_rdata=0xDEADBEEF, err=0, 2 cycles after accept.
- Mem word 4 preloaded 0x11223344; byte store addr 0x12 data 0xAA -> READ then MERGE, mem_din=0x11AA3344, resp_valid 3 cycles after accept.
- Preload 0x80FF7F01:
  - byte load addr 0x3 signed -> 0xFFFFFF80
  - byte load addr 0x3 unsigned -> 0x00000080
  - half load addr 0x2 signed -> 0xFFFF80FF
- Half load addr 0x1, and word store addr 0x6 -> resp_err=1 one cycle after accept, mem_we never asserted, resp_rdata=0. Also size=11 -> resp_err=1.
- Sub-word store in progress, rst_n pulled low during READ -> no mem_we pulse, resp_valid=0, req_ready=1 after reset release, memory unchanged.
- With DMEM_RANGE_CHK_EN: word load addr 0x0001_0000 -> resp_err=1. Without it: the same request reads word 0 with err=0.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: load/store sequencer for a word-wide sync data memory.
// Optional macro DMEM_RANGE_CHK_EN flags nonzero upper address bits as errors.
module dmem_access_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MERGE,
    S_WRITE,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic              c_we;
  logic [1:0]        c_size;
  logic              c_uns;
  logic [ADDR_W+1:0] c_addr;
  logic [31:0]       c_wdata;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic        acc;
  logic        bad;
  logic [4:0]  sh;
  logic [31:0] lmask;
  logic [31:0] shv;
  logic [31:0] merged;
  logic [31:0] ext;
  logic [31:0] live;

  assign req_ready  = (state_q == S_IDLE);
  assign acc        = req_valid && req_ready;
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = err_q;
  assign mem_addr   = c_addr[ADDR_W+1:2];
  assign mem_we     = (state_q == S_MERGE) || (state_q == S_WRITE);

`ifndef DMEM_RANGE_CHK_EN
  logic unused_hi;
  assign unused_hi = ^req_addr[31:ADDR_W+2];
`endif

  // Classify the incoming request: illegal size or misalignment.
  always_comb begin
    bad = 1'b0;
    unique case (req_size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = req_addr[0];
      2'b10:   bad = |req_addr[1:0];
      default: bad = 1'b1;
    endcase
`ifdef DMEM_RANGE_CHK_EN
    if (|req_addr[31:ADDR_W+2]) bad = 1'b1;
`endif
  end

  // Lane shift, read-modify-write merge and load extension.
  always_comb begin
    sh     = (c_size == 2'b00) ? {c_addr[1:0], 3'b000}
                               : {c_addr[1], 4'b0000};
    lmask  = (c_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    merged = (mem_dout & ~(lmask << sh))
           | ((c_wdata & lmask) << sh);
    shv    = mem_dout >> sh;
    ext    = mem_dout;
    unique case (c_size)
      2'b00:   ext = {{24{~c_uns & shv[7]}}, shv[7:0]};
      2'b01:   ext = {{16{~c_uns & shv[15]}}, shv[15:0]};
      default: ext = mem_dout;
    endcase
  end

  // Load data comes straight off the registered memory output in RESP,
  // then is held in rdata_q until the next response.
  always_comb begin
    live = 32'h0;
    if (resp_valid && !c_we && !err_q) live = ext;
    resp_rdata = resp_valid ? live : rdata_q;
  end

  // Memory write data for MERGE and WRITE.
  always_comb begin
    mem_din = 32'h0;
    unique case (1'b1)
      (state_q == S_MERGE): mem_din = merged;
      (state_q == S_WRITE): mem_din = c_wdata;
      default:              mem_din = 32'h0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          if (bad)
            state_d = S_RESP;
          else if (req_we && req_size == 2'b10)
            state_d = S_WRITE;
          else
            state_d = S_READ;
        end
      end
      S_READ:  state_d = c_we ? S_MERGE : S_RESP;
      S_MERGE: state_d = S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, request capture and response hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      c_we    <= 1'b0;
      c_size  <= 2'b00;
      c_uns   <= 1'b0;
      c_addr  <= '0;
      c_wdata <= 32'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        c_we    <= req_we;
        c_size  <= req_size;
        c_uns   <= req_unsigned;
        c_addr  <= req_addr[ADDR_W+1:0];
        c_wdata <= req_wdata;
      end
      if (state_q != S_RESP && state_d == S_RESP)
        err_q <= (state_q == S_IDLE);
      if (resp_valid)
        rdata_q <= live;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: scoreboard bench with a byte-array reference model.
// Honours DMEM_RANGE_CHK_EN the same way the design does.
module tb_dmem_access_ctrl;

  localparam int AW = 12;
  localparam int NW = 1 << AW;
  localparam int NB = NW * 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout = 32'h0;

  dmem_access_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:NW-1];
  logic [7:0]  ref_b [0:NB-1];

  // Data memory: one-cycle registered read, word write.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwe;
    int          acc;
    int          we0;
  } exp_t;

  exp_t exp_q[$];

  int cyc = 0;
  int we_cnt = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;
  logic        prev_rv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: count write pulses, compare each response against the queue.
  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (prev_rv && !resp_valid) begin
      chk("hold_rdata", resp_rdata, last_rdata);
      chk("hold_err", {31'h0, resp_err}, {31'h0, last_err});
    end
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rdata", resp_rdata, e.rdata);
        chk("err", {31'h0, resp_err}, {31'h0, e.err});
        chk("latency", cyc - e.acc + 1, e.lat);
        chk("we_pulses", we_cnt - e.we0, e.nwe);
        chk("ready_in_resp", {31'h0, req_ready}, 32'h0);
      end
      last_rdata = resp_rdata;
      last_err   = resp_err;
    end
    prev_rv = resp_valid;
  end

  function automatic bit ref_is_err(input logic [1:0] sz,
                                    input logic [31:0] a);
    bit e;
    e = (sz == 2'b11) || (sz == 2'b01 && a[0])
     || (sz == 2'b10 && a[1:0] != 2'b00);
`ifdef DMEM_RANGE_CHK_EN
    if (a[31:AW+2] != 0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz,
                                           input logic uns,
                                           input logic [31:0] a);
    longint v;
    int n;
    int idx;
    v = 0;
    n = nbytes(sz);
    idx = int'(a) % NB;
    if (idx < 0) idx += NB;
    for (int i = 0; i < n; i++)
      v += longint'(ref_b[idx + i]) * (longint'(1) << (8 * i));
    if (n < 4 && !uns && v >= (longint'(1) << (8 * n - 1)))
      v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d);
    int idx;
    logic [31:0] t;
    idx = int'(a[AW+1:0]);
    t = d;
    for (int i = 0; i < nbytes(sz); i++) begin
      ref_b[idx + i] = t[7:0];
      t = t >> 8;
    end
  endtask

  task automatic preload(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int i = 0; i < 4; i++) ref_b[4 * w + i] = v[8 * i +: 8];
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("resp_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a,
                       input logic [31:0] d);
    exp_t e;
    bit er;
    int k;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_size = sz;
    req_unsigned = uns;
    req_addr = a;
    req_wdata = d;
    for (k = 0; k < 12 && !req_ready; k++) @(negedge clk);
    if (!req_ready) begin
      chk("accept_timeout", 32'h0, 32'h1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    er = ref_is_err(sz, a);
    e.err = er;
    e.acc = cyc;
    e.we0 = we_cnt;
    e.nwe = (we && !er) ? 1 : 0;
    if (er) begin
      e.lat = 1;
      e.rdata = 32'h0;
    end else if (we) begin
      e.lat = (sz == 2'b10) ? 2 : 3;
      e.rdata = 32'h0;
      ref_store(sz, a, d);
    end else begin
      e.lat = 2;
      e.rdata = ref_load(sz, uns, a);
    end
    exp_q.push_back(e);
    req_we = $urandom % 2;
    req_size = 2'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    drain();
  endtask

  int bad_words;
  logic [31:0] w;
  logic [31:0] ra;

  initial begin
    for (int i = 0; i < NW; i++) preload(i, $urandom);
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mem_addr", {20'h0, mem_addr}, 32'h0);
    chk("rst_mem_we_din", {mem_din[30:0], mem_we}, 32'h0);
    rst_n = 1'b1;

    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("word_store_mem", mem[4], 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("word_load_val", last_rdata, 32'hDEADBEEF);

    preload(4, 32'h11223344);
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA);
    chk("byte_rmw_mem", mem[4], 32'h11AA3344);

    preload(0, 32'h80FF7F01);
    issue(1'b0, 2'b00, 1'b0, 32'h3, 32'h0);
    chk("lb_signed", last_rdata, 32'hFFFFFF80);
    issue(1'b0, 2'b00, 1'b1, 32'h3, 32'h0);
    chk("lb_unsigned", last_rdata, 32'h00000080);
    issue(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
    chk("lh_signed", last_rdata, 32'hFFFF80FF);

    issue(1'b0, 2'b01, 1'b0, 32'h1, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h6, 32'h12345678);
    issue(1'b0, 2'b11, 1'b0, 32'h8, 32'h0);
    chk("err_last", {31'h0, last_err}, 32'h1);

    issue(1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0);

    preload(5, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = 2'b00;
    req_addr = 32'h15;
    req_wdata = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    w = we_cnt;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mid_valid", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_mid_pulses", we_cnt - w, 0);
    chk("rst_mid_mem", mem[5], 32'hCAFEF00D);

    for (int t = 0; t < 400; t++) begin
      ra = $urandom_range(0, 63);
      if ($urandom % 8 == 0) ra |= 32'h1 << $urandom_range(AW + 2, 31);
      issue($urandom % 2, ($urandom % 5 == 0) ? 2'b11 : 2'($urandom % 3),
            $urandom % 2, ra, $urandom);
    end

    repeat (3) @(negedge clk);
    bad_words = 0;
    for (int i = 0; i < NW; i++) begin
      w = {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
      if (mem[i] !== w) bad_words++;
    end
    chk("mem_image", bad_words, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
